// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: state encodings, ALU opcodes and frame order shared by both ends of the UART ALU link.
package uart_alu_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_FLUSH, ST_SEND_A, ST_SEND_B, ST_SEND_OP, ST_WAIT_RES
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // Bytes go out on the wire in this order; the ALU side receives them the same way.
    typedef enum logic [1:0] {FRAME_A, FRAME_B, FRAME_OP} frame_t;
endpackage

// File: rtl/timeout_timer.sv
// timeout_timer: cycle counter that flags the last cycle of a LIMIT-cycle window.
module timeout_timer #(
    parameter int LIMIT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            count_q <= '0;
        else if (i_clear)
            count_q <= '0;
        else if (i_enable)
            count_q <= count_q + 1'b1;
    end

    assign o_expired = count_q == W'(LIMIT - 1);
endmodule

// File: rtl/uart_alu_host.sv
// uart_alu_host: frames A, B and opcode into the UART TX FIFO and collects the one-byte result,
// reporting completion with o_done or a timeout when no result arrives.
module uart_alu_host
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OPCODE_SZ      = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic [OPCODE_SZ-1:0]  i_op_code,
    input  logic                  i_tx_full,
    input  logic                  i_rx_empty,
    input  logic [DATA_WIDTH-1:0] i_r_data,
    output logic [DATA_WIDTH-1:0] o_w_data,
    output logic                  o_wr_uart,
    output logic                  o_rd_uart,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_busy
);
    state_t                state_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, w_data_q, result_q;
    logic [OPCODE_SZ-1:0]  op_q;
    logic                  wr_q, rd_q, done_q, timeout_q, expired;

    // A strobe issued last cycle blocks the next one so the FIFO flags have caught up.
    wire send_ok = !i_tx_full && !wr_q;
    wire rx_ok   = !i_rx_empty && !rd_q;

    timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (state_q == ST_SEND_OP && send_ok),
        .i_enable (state_q == ST_WAIT_RES),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            w_data_q  <= '0;
            result_q  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (i_start) begin
                    a_q       <= i_op_a;
                    b_q       <= i_op_b;
                    op_q      <= i_op_code;
                    timeout_q <= 1'b0;
                    state_q   <= ST_FLUSH;
                end
                ST_FLUSH: if (!rd_q) begin
                    if (i_rx_empty) state_q <= ST_SEND_A;
                    else            rd_q    <= 1'b1;
                end
                ST_SEND_A: if (send_ok) begin
                    w_data_q <= a_q;
                    wr_q     <= 1'b1;
                    state_q  <= ST_SEND_B;
                end
                ST_SEND_B: if (send_ok) begin
                    w_data_q <= b_q;
                    wr_q     <= 1'b1;
                    state_q  <= ST_SEND_OP;
                end
                ST_SEND_OP: if (send_ok) begin
                    w_data_q <= DATA_WIDTH'(op_q);
                    wr_q     <= 1'b1;
                    state_q  <= ST_WAIT_RES;
                end
                ST_WAIT_RES: if (rx_ok) begin
                    result_q <= i_r_data;
                    rd_q     <= 1'b1;
                    done_q   <= 1'b1;
                    state_q  <= ST_IDLE;
                end else if (expired) begin
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_w_data  = w_data_q;
    assign o_wr_uart = wr_q;
    assign o_rd_uart = rd_q;
    assign o_result  = result_q;
    assign o_done    = done_q;
    assign o_timeout = timeout_q;
    assign o_busy    = state_q != ST_IDLE;
endmodule

// File: doc/uart_alu_host.md
# uart_alu_host

Host-side initiator for the UART ALU link. On a start pulse it frames operand A, operand B and the opcode as three bytes into the local UART TX FIFO, then waits for the one-byte result in the local UART RX FIFO. It returns the result with a done pulse, or flags a timeout. It sits between board I/O (switches and button) and a `uart` TX/RX FIFO pair, and talks to the ALU-side interface on the far end of the serial line.

## Interface
- `DATA_WIDTH`, 8: UART word width; operand width.
- `OPCODE_SZ`, 6: ALU opcode width; must be ≤ `DATA_WIDTH`.
- `TIMEOUT_CYCLES`, 1_000_000: maximum number of cycles spent in WAIT_RES; counter width is clog2(`TIMEOUT_CYCLES`).
- `i_clk` in 1: single clock.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_start` in 1: request pulse; sampled only in IDLE.
- `i_op_a`, `i_op_b` in `DATA_WIDTH`: operands; latched when the start is accepted.
- `i_op_code` in `OPCODE_SZ`: opcode; latched when the start is accepted.
- `i_tx_full` in 1: TX FIFO full.
- `i_rx_empty` in 1: RX FIFO empty.
- `i_r_data` in `DATA_WIDTH`: RX FIFO head word; valid while `i_rx_empty`=0.
- `o_w_data` out `DATA_WIDTH`: TX FIFO write data; registered.
- `o_wr_uart` out 1: TX FIFO write strobe; registered, one-cycle pulses.
- `o_rd_uart` out 1: RX FIFO pop strobe; registered, one-cycle pulses.
- `o_result` out `DATA_WIDTH`: last received result; holds its value until the next capture.
- `o_done` out 1: one-cycle pulse at the end of every transaction.
- `o_timeout` out 1: set when a transaction ends with no result; cleared when the next start is accepted.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: if `i_start`=1, latch A, B and opcode, clear `o_timeout`, go to FLUSH.
  - FLUSH: pop stale RX bytes left over from earlier timeouts.
    - If `i_rx_empty`=0 and `o_rd_uart`=0, pulse `o_rd_uart`.
    - If `i_rx_empty`=1 and `o_rd_uart`=0, go to SEND_A.
  - SEND_A, SEND_B, SEND_OP: each issues a write only when `i_tx_full`=0 and `o_wr_uart`=0. The write sets `o_w_data` (A, then B, then {zeros, opcode} zero-extended) and `o_wr_uart`=1 for one cycle, and advances to the next state. SEND_OP advances to WAIT_RES, clearing the timeout counter. While the FIFO is full the state holds and no strobe is issued.
  - WAIT_RES: the counter increments every cycle.
    - If `i_rx_empty`=0 and `o_rd_uart`=0: capture `o_result`=`i_r_data`, pulse `o_rd_uart` and `o_done`, go to IDLE.
    - Else if the count equals `TIMEOUT_CYCLES`-1: set `o_timeout`=1, pulse `o_done`, go to IDLE. `o_result` is unchanged.
  - Undefined encodings go to IDLE.
- `i_start` while busy is ignored.
- A result arriving on the same cycle the timeout limit is reached wins; no timeout is flagged.
- Reset value of every output is 0; the latched operands and the counter also reset to 0.
- Reset mid-transaction returns to IDLE. Bytes already written to the TX FIFO are not recalled. A late result left in the RX FIFO is discarded by FLUSH on the next start.

## Timing
- Start sampled at edge k:
  - FLUSH from k+1.
  - With the RX FIFO empty and the TX FIFO not full, write strobes are high after edges k+2 (A), k+4 (B) and k+6 (opcode).
  - WAIT_RES begins after edge k+6.
- Strobes are never asserted on consecutive cycles, so minimum byte spacing is 2 cycles. This guarantees each full/empty flag reflects the previous strobe before it is used.
- Result latency: `o_done` and `o_rd_uart` go high one edge after the first WAIT_RES cycle that sees `i_rx_empty`=0. `o_result` is valid in the same cycle as `o_done`.
- Timeout: `o_done`=1 and `o_timeout`=1 become visible exactly `TIMEOUT_CYCLES` cycles after WAIT_RES is entered.
- A new start is accepted from the cycle after `o_done`.

## Structure
- Shared package `uart_alu_pkg` holds:
  - state encodings;
  - ALU opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010), which the ALU-side interface reuses;
  - the frame order A, B, opcode.
- One sub-module, `timeout_timer`, with inputs clear and enable, a `LIMIT` parameter, and output `expired`. The FSM and the datapath registers remain in `uart_alu_host`.

## Test plan
- Basic transaction: A=0x05, B=0x03, op=ADD, start pulse, TX FIFO never full. Writes 0x05, 0x03, 0x20 appear in order at 2-cycle spacing. Then inject RX byte 0x08: `o_result`=0x08, exactly one `o_rd_uart` pulse, one `o_done` pulse, `o_timeout`=0.
- TX backpressure: hold `i_tx_full`=1 for 10 cycles during SEND_B. No strobe while full, 0x03 is written after release, byte order is intact.
- Timeout: `TIMEOUT_CYCLES`=16, no RX data. `o_done`=1 and `o_timeout`=1 exactly 16 cycles after WAIT_RES entry; `o_result` keeps its prior value. The next start clears `o_timeout`.
- Stale flush: preload two RX bytes 0xAA and 0xBB, then start. Two pops occur before the first TX write. The later result 0x11 is captured, not 0xAA.
- Start while busy, and simultaneous result with timeout at the limit: the extra start is ignored; the result is captured and `o_timeout`=0.
- Reset asserted after the B write: all outputs are 0 immediately, state is IDLE, and a following transaction completes normally.
